// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared VGA timing constants for 640x480@60 (25 MHz pixel rate), the
//   derivation of total line/frame lengths, sync-polarity constants and a
//   small helper that maps "inside the sync pulse" onto the output level.
//   No ports; imported by vga_sync_gen.
// ----------------------------------------------------------------------------
package vga_timing_pkg;

    // Horizontal timing, in pixels
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;

    // Vertical timing, in lines
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    // Sync polarity: the level driven while the sync pulse is active
    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // Full period of one axis (visible + porches + sync)
    function automatic int span_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    localparam int VGA_H_TOTAL = span_total(VGA_H_VISIBLE, VGA_H_FRONT,
                                            VGA_H_SYNC, VGA_H_BACK);   // 800
    localparam int VGA_V_TOTAL = span_total(VGA_V_VISIBLE, VGA_V_FRONT,
                                            VGA_V_SYNC, VGA_V_BACK);   // 525

    // Output level of a sync line given whether the pulse is active
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// ----------------------------------------------------------------------------
// mod_counter
//   Modulo-N up counter with enable. Counts 0..N-1 and wraps to 0.
//   carry is combinational: high on the cycle an enabled count will wrap,
//   so it can directly enable a cascaded counter.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset (count -> 0)
//   en     in   advance enable
//   count  out  current count, WIDTH bits
//   carry  out  en && count == N-1
// ----------------------------------------------------------------------------
module mod_counter #(
    parameter int N     = 800,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             carry
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

    assign carry = en && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= carry ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// ----------------------------------------------------------------------------
// vga_sync_gen
//   VGA horizontal/vertical timing generator running in the system clock
//   domain, advanced by a one-clk pixel enable from the clock divider.
//   Two cascaded mod_counters hold the raw position; the top decodes sync
//   and visible regions and registers every output, so all outputs lag the
//   counters by one clk and are mutually aligned.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   pix_tick     in   pixel enable (may be held high continuously)
//   hsync        out  horizontal sync, active level SYNC_POL
//   vsync        out  vertical sync, active level SYNC_POL
//   video_on     out  displayed coordinate is inside the visible area
//   pix_x        out  displayed horizontal coordinate, CNT_W bits
//   pix_y        out  displayed vertical coordinate, CNT_W bits
//   frame_start  out  one-clk pulse alongside the first display of (0,0)
//                     after a frame wrap (none for the first frame after reset)
// Counter width must satisfy H_TOTAL <= 2**CNT_W and V_TOTAL <= 2**CNT_W.
// ----------------------------------------------------------------------------
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE = VGA_H_VISIBLE,
    parameter int   H_FRONT   = VGA_H_FRONT,
    parameter int   H_SYNC    = VGA_H_SYNC,
    parameter int   H_BACK    = VGA_H_BACK,
    parameter int   V_VISIBLE = VGA_V_VISIBLE,
    parameter int   V_FRONT   = VGA_V_FRONT,
    parameter int   V_SYNC    = VGA_V_SYNC,
    parameter int   V_BACK    = VGA_V_BACK,
    parameter logic SYNC_POL  = SYNC_ACTIVE_LOW,
    parameter int   CNT_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_tick,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_start
);

    localparam int H_TOTAL = span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    // Inclusive sync windows and visible limits in counter width
    localparam logic [CNT_W-1:0] H_SYNC_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SYNC_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [CNT_W-1:0] H_VIS_LIMIT  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_LIMIT  = CNT_W'(V_VISIBLE);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             line_carry;
    logic             frame_wrap;

    // Horizontal counter advances on each pixel tick
    mod_counter #(
        .N     (H_TOTAL),
        .WIDTH (CNT_W)
    ) u_h_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (pix_tick),
        .count (h_cnt),
        .carry (line_carry)
    );

    // Vertical counter advances only on a line carry; its carry is therefore
    // a tick taken at (H_TOTAL-1, V_TOTAL-1), i.e. the frame wrap.
    mod_counter #(
        .N     (V_TOTAL),
        .WIDTH (CNT_W)
    ) u_v_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (line_carry),
        .count (v_cnt),
        .carry (frame_wrap)
    );

    // Region decode of the current counter position
    logic h_sync_zone;
    logic v_sync_zone;
    logic visible;

    always_comb begin
        h_sync_zone = (h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST);
        v_sync_zone = (v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST);
        visible     = (h_cnt < H_VIS_LIMIT) && (v_cnt < V_VIS_LIMIT);
    end

    // frame_wrap_q is in phase with the counters (high on the clk they read
    // (0,0) after a wrap); one more register lines frame_start up with the
    // registered coordinates. frame_wrap needs pix_tick and the counters
    // move on that tick, so the pulse is one clk wide for any tick spacing.
    logic frame_wrap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync        <= ~SYNC_POL;
            vsync        <= ~SYNC_POL;
            video_on     <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            frame_wrap_q <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            hsync        <= sync_level(h_sync_zone, SYNC_POL);
            vsync        <= sync_level(v_sync_zone, SYNC_POL);
            video_on     <= visible;
            pix_x        <= h_cnt;
            pix_y        <= v_cnt;
            frame_wrap_q <= frame_wrap;
            frame_start  <= frame_wrap_q;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_gen
//   Directed bench for vga_sync_gen. Instance dut_a uses the default
//   640x480 timing (active-low syncs) for reset, horizontal, line-wrap, stall
//   and mid-frame reset scenarios. Instance dut_b uses a small 32x20 raster
//   with active-high syncs so whole frames fit in a short run:
//     H: visible 20, front 4, sync 6, back 2  -> hsync active x in [24,29]
//     V: visible 12, front 3, sync 2, back 3  -> vsync active y in [15,16]
//     frame = 32*20 = 640 ticks
// ----------------------------------------------------------------------------
module tb_vga_sync_gen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, tick_a, rst_b, tick_b;
    logic       a_hsync, a_vsync, a_video_on, a_frame_start;
    logic [9:0] a_pix_x, a_pix_y;
    logic       b_hsync, b_vsync, b_video_on, b_frame_start;
    logic [5:0] b_pix_x, b_pix_y;

    int checks = 0;
    int errors = 0;

    vga_sync_gen dut_a (
        .clk         (clk),
        .rst         (rst_a),
        .pix_tick    (tick_a),
        .hsync       (a_hsync),
        .vsync       (a_vsync),
        .video_on    (a_video_on),
        .pix_x       (a_pix_x),
        .pix_y       (a_pix_y),
        .frame_start (a_frame_start)
    );

    vga_sync_gen #(
        .H_VISIBLE (20), .H_FRONT (4), .H_SYNC (6), .H_BACK (2),
        .V_VISIBLE (12), .V_FRONT (3), .V_SYNC (2), .V_BACK (3),
        .SYNC_POL  (1'b1), .CNT_W (6)
    ) dut_b (
        .clk         (clk),
        .rst         (rst_b),
        .pix_tick    (tick_b),
        .hsync       (b_hsync),
        .vsync       (b_vsync),
        .video_on    (b_video_on),
        .pix_x       (b_pix_x),
        .pix_y       (b_pix_y),
        .frame_start (b_frame_start)
    );

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic step_a(input logic t);
        tick_a = t;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic t);
        tick_b = t;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [23:0] rst_vec;
        int bad;
        rst_a = 1'b0;
        for (int i = 0; i < 50; i++) step_a(1'b1);
        checks++;
        if (a_pix_x !== 10'd49) begin
            errors++;
            $display("FAIL pre_reset_pix_x: got %0d expected 49", a_pix_x);
        end
        // Assert reset between edges; outputs must clear without a clk edge
        #3;
        rst_a  = 1'b1;
        tick_a = 1'b1;
        #1;
        checks++;
        if (a_hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b expected 1", a_hsync); end
        checks++;
        if (a_vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b expected 1", a_vsync); end
        checks++;
        if (a_video_on !== 1'b0) begin errors++; $display("FAIL reset_video_on: got %b expected 0", a_video_on); end
        checks++;
        if (a_pix_x !== 10'd0) begin errors++; $display("FAIL reset_pix_x: got %0d expected 0", a_pix_x); end
        checks++;
        if (a_pix_y !== 10'd0) begin errors++; $display("FAIL reset_pix_y: got %0d expected 0", a_pix_y); end
        checks++;
        if (a_frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", a_frame_start); end
        // Hold for 3 clks with pix_tick toggling
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step_a(i[0]);
            rst_vec = {a_hsync, a_vsync, a_video_on, a_pix_x, a_pix_y, a_frame_start};
            if (rst_vec !== {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0}) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_hold: got %0d bad clks expected 0", bad); end
        // Release; first edge shows the decode of (0,0)
        rst_a = 1'b0;
        step_a(1'b0);
        checks++;
        if (a_video_on !== 1'b1) begin errors++; $display("FAIL release_video_on: got %b expected 1", a_video_on); end
        checks++;
        if ({a_pix_x, a_pix_y} !== 20'd0) begin
            errors++;
            $display("FAIL release_pix: got (%0d,%0d) expected (0,0)", a_pix_x, a_pix_y);
        end
        checks++;
        if ({a_hsync, a_vsync, a_frame_start} !== 3'b110) begin
            errors++;
            $display("FAIL release_sync: got %b expected 110", {a_hsync, a_vsync, a_frame_start});
        end
    endtask

    task automatic test_horizontal();
        int  vis_vals = 0;
        int  low_clks = 0;
        int  fall_x   = -1;
        int  rise_x   = -1;
        int  prev_x   = -1;
        logic prev_hs = 1'b1;
        bit  done     = 1'b0;
        // pix_tick every 4th clk; run until line 1 is displayed
        for (int k = 2; k < 5000 && !done; k++) begin
            step_a(k % 4 == 0);
            if (a_pix_y == 10'd0) begin
                if (a_video_on && int'(a_pix_x) != prev_x) vis_vals++;
                if (!a_hsync) low_clks++;
                if (prev_hs && !a_hsync && fall_x < 0) fall_x = int'(a_pix_x);
                if (!prev_hs && a_hsync && rise_x < 0) rise_x = int'(a_pix_x);
            end else begin
                done = 1'b1;
            end
            prev_x  = int'(a_pix_x);
            prev_hs = a_hsync;
        end
        checks++;
        if (!done) begin errors++; $display("FAIL h_line_timeout: got no line end expected line 1"); end
        checks++;
        if (vis_vals != 640) begin errors++; $display("FAIL h_visible_ticks: got %0d expected 640", vis_vals); end
        checks++;
        if (low_clks != 384) begin errors++; $display("FAIL hsync_low_clks: got %0d expected 384", low_clks); end
        checks++;
        if (fall_x != 656) begin errors++; $display("FAIL hsync_fall_x: got %0d expected 656", fall_x); end
        checks++;
        if (rise_x != 752) begin errors++; $display("FAIL hsync_rise_x: got %0d expected 752", rise_x); end
        checks++;
        if ({a_pix_x, a_pix_y} !== {10'd0, 10'd1}) begin
            errors++;
            $display("FAIL h_wrap_pix: got (%0d,%0d) expected (0,1)", a_pix_x, a_pix_y);
        end
    endtask

    task automatic test_line_wrap();
        int bad_vid = 0;
        bit found   = 1'b0;
        for (int k = 0; k < 10000 && !found; k++) begin
            step_a(1'b1);
            if (a_pix_y == 10'd10 && a_pix_x >= 10'd640 && a_video_on) bad_vid++;
            if (a_pix_y == 10'd10 && a_pix_x == 10'd799) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL wrap_reach_timeout: got no (799,10) expected reached"); end
        checks++;
        if (bad_vid != 0) begin errors++; $display("FAIL wrap_blank_video: got %0d high clks expected 0", bad_vid); end
        step_a(1'b1);
        checks++;
        if ({a_pix_x, a_pix_y} !== {10'd0, 10'd11}) begin
            errors++;
            $display("FAIL wrap_next_pix: got (%0d,%0d) expected (0,11)", a_pix_x, a_pix_y);
        end
        checks++;
        if (a_video_on !== 1'b1) begin errors++; $display("FAIL wrap_next_video: got %b expected 1", a_video_on); end
    endtask

    task automatic test_stall();
        bit found = 1'b0;
        int bad   = 0;
        for (int k = 0; k < 1000 && !found; k++) begin
            step_a(1'b1);
            if (a_pix_x == 10'd299 && a_pix_y == 10'd11) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL stall_reach_timeout: got no (299,11) expected reached"); end
        // Counter now holds 300; keep pix_tick low for 100 clks
        for (int i = 0; i < 100; i++) begin
            step_a(1'b0);
            if ({a_hsync, a_vsync, a_video_on, a_pix_x, a_pix_y, a_frame_start}
                !== {1'b1, 1'b1, 1'b1, 10'd300, 10'd11, 1'b0}) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stall_frozen: got %0d changed clks expected 0", bad); end
        step_a(1'b1);
        checks++;
        if (a_pix_x !== 10'd300) begin errors++; $display("FAIL stall_resume0: got %0d expected 300", a_pix_x); end
        step_a(1'b1);
        checks++;
        if (a_pix_x !== 10'd301) begin errors++; $display("FAIL stall_resume1: got %0d expected 301", a_pix_x); end
    endtask

    task automatic test_mid_reset();
        int bad   = 0;
        int fs_n  = 0;
        int pos_bad = 0;
        checks++;
        if ({a_pix_x, a_pix_y} !== {10'd301, 10'd11}) begin
            errors++;
            $display("FAIL mid_pre_pix: got (%0d,%0d) expected (301,11)", a_pix_x, a_pix_y);
        end
        #4;
        rst_a = 1'b1;
        #1;
        checks++;
        if ({a_hsync, a_vsync, a_video_on, a_pix_x, a_pix_y, a_frame_start}
            !== {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_async_clear: got (%0d,%0d) hs=%b vs=%b vid=%b expected (0,0) hs=1 vs=1 vid=0",
                     a_pix_x, a_pix_y, a_hsync, a_vsync, a_video_on);
        end
        for (int i = 0; i < 2; i++) begin
            step_a(1'b1);
            if ({a_pix_x, a_pix_y, a_video_on} !== 21'd0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mid_hold: got %0d bad clks expected 0", bad); end
        rst_a = 1'b0;
        for (int j = 0; j < 900; j++) begin
            step_a(1'b1);
            if (int'(a_pix_x) != j % 800 || int'(a_pix_y) != j / 800) pos_bad++;
            if (a_frame_start) fs_n++;
        end
        checks++;
        if (pos_bad != 0) begin errors++; $display("FAIL mid_restart_pos: got %0d bad clks expected 0", pos_bad); end
        checks++;
        if (fs_n != 0) begin errors++; $display("FAIL mid_restart_fs: got %0d pulses expected 0", fs_n); end
    endtask

    task automatic test_frame();
        int n_fs = 0, first_fs = -1, second_fs = -1;
        int fs_pos_bad = 0, fs_wide = 0;
        int bad_h = 0, bad_v = 0, bad_vid = 0, vs_ticks = 0;
        int prev_x = -1;
        logic prev_fs = 1'b0;
        logic exp_h, exp_v, exp_vid;
        // Active-high syncs: reset level is 0
        checks++;
        if ({b_hsync, b_vsync, b_video_on, b_frame_start} !== 4'b0000) begin
            errors++;
            $display("FAIL b_reset: got %b expected 0000", {b_hsync, b_vsync, b_video_on, b_frame_start});
        end
        rst_b = 1'b0;
        // pix_tick every 2nd clk; two full frames fit in 2560 clks
        for (int k = 1; k <= 2700; k++) begin
            step_b(k % 2 == 0);
            exp_h   = (b_pix_x >= 6'd24) && (b_pix_x <= 6'd29);
            exp_v   = (b_pix_y >= 6'd15) && (b_pix_y <= 6'd16);
            exp_vid = (b_pix_x < 6'd20) && (b_pix_y < 6'd12);
            if (b_hsync !== exp_h) bad_h++;
            if (b_vsync !== exp_v) bad_v++;
            if (b_video_on !== exp_vid) bad_vid++;
            if (k < 1281 && b_vsync && int'(b_pix_x) != prev_x) vs_ticks++;
            if (b_frame_start) begin
                if (n_fs == 0) first_fs = k;
                else if (n_fs == 1) second_fs = k;
                n_fs++;
                if ({b_pix_x, b_pix_y} !== 12'd0) fs_pos_bad++;
                if (prev_fs) fs_wide++;
            end
            prev_fs = b_frame_start;
            prev_x  = int'(b_pix_x);
        end
        checks++;
        if (bad_h != 0) begin errors++; $display("FAIL b_hsync_window: got %0d bad clks expected 0", bad_h); end
        checks++;
        if (bad_v != 0) begin errors++; $display("FAIL b_vsync_window: got %0d bad clks expected 0", bad_v); end
        checks++;
        if (bad_vid != 0) begin errors++; $display("FAIL b_video_window: got %0d bad clks expected 0", bad_vid); end
        checks++;
        if (vs_ticks != 64) begin errors++; $display("FAIL b_vsync_ticks: got %0d expected 64", vs_ticks); end
        checks++;
        if (n_fs != 2) begin errors++; $display("FAIL b_fs_count: got %0d expected 2", n_fs); end
        checks++;
        if (first_fs != 1281) begin errors++; $display("FAIL b_fs_first: got %0d expected 1281", first_fs); end
        checks++;
        if (second_fs != 2561) begin errors++; $display("FAIL b_fs_second: got %0d expected 2561", second_fs); end
        checks++;
        if (fs_pos_bad != 0) begin errors++; $display("FAIL b_fs_at_origin: got %0d off-origin expected 0", fs_pos_bad); end
        checks++;
        if (fs_wide != 0) begin errors++; $display("FAIL b_fs_width: got %0d wide pulses expected 0", fs_wide); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        tick_a = 1'b0;
        tick_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_horizontal();
        test_line_wrap();
        test_stall();
        test_mid_reset();
        tick_a = 1'b0;
        test_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
